// File: rtl/instr_decode_pipe_pkg.sv
// Decode constants shared by the D stage and the hazard unit:
// opcodes/functs, one-hot type bit indices, Tuse/Tnew encodings.
package instr_decode_pipe_pkg;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam int T_ADDU  = 0;
  localparam int T_SUBU  = 1;
  localparam int T_SLL   = 2;
  localparam int T_JR    = 3;
  localparam int T_ORI   = 4;
  localparam int T_LW    = 5;
  localparam int T_SW    = 6;
  localparam int T_BEQ   = 7;
  localparam int T_LUI   = 8;
  localparam int T_J     = 9;
  localparam int T_JAL   = 10;
  localparam int T_ADDIU = 11;
  localparam int T_ANDI  = 12;
  localparam int T_BNE   = 13;
  localparam int T_LB    = 14;
  localparam int T_SB    = 15;
  localparam int T_SLT   = 16;
  localparam int T_JALR  = 17;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  typedef enum logic [3:0] {
    C_ERR, C_ALU_R, C_ALU_I, C_LOAD, C_STORE,
    C_BR, C_JR, C_JALR, C_J, C_JAL
  } iclass_t;

  typedef enum logic [1:0] {
    D_NONE, D_RD, D_RT, D_R31
  } dsel_t;

  typedef struct packed {
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew;
    dsel_t      dsel;
  } hz_t;

  function automatic hz_t class_info(iclass_t c);
    hz_t h;
    h = '{TUSE_NONE, TUSE_NONE, TNEW_NONE, D_NONE};
    unique case (c)
      C_ALU_R: h = '{TUSE_1, TUSE_1, TNEW_ALU, D_RD};
      C_ALU_I: h = '{TUSE_1, TUSE_NONE, TNEW_ALU, D_RT};
      C_LOAD:  h = '{TUSE_1, TUSE_NONE, TNEW_LOAD, D_RT};
      C_STORE: h = '{TUSE_1, TUSE_2, TNEW_NONE, D_NONE};
      C_BR:    h = '{TUSE_0, TUSE_0, TNEW_NONE, D_NONE};
      C_JR:    h = '{TUSE_0, TUSE_NONE, TNEW_NONE, D_NONE};
      C_JALR:  h = '{TUSE_0, TUSE_NONE, TNEW_NONE, D_RD};
      C_JAL:   h = '{TUSE_NONE, TUSE_NONE, TNEW_NONE, D_R31};
      default: h = '{TUSE_NONE, TUSE_NONE, TNEW_NONE, D_NONE};
    endcase
    return h;
  endfunction

endpackage

// File: rtl/instr_type_lut.sv
// Combinational decoder: instr -> one-hot type, dst, Tuse, Tnew, illegal.
// Extended instructions decode only when EXT_EN != 0.
module instr_type_lut
  import instr_decode_pipe_pkg::*;
#(
  parameter int NUM_TYPES = 64,
  parameter int EXT_EN    = 1
) (
  input  logic [31:0]          instr,
  output logic [NUM_TYPES-1:0] itype,
  output logic [4:0]           dst,
  output logic [1:0]           tuse_rs,
  output logic [1:0]           tuse_rt,
  output logic [1:0]           tnew,
  output logic                 illegal
);

  localparam logic EXT = (EXT_EN != 0);

  logic [5:0] op;
  logic [5:0] fn;
  logic       r;
  iclass_t    cls;
  hz_t        hz;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign r  = (op == OP_R);

  always_comb begin
    itype = '0;
    cls   = C_ERR;
    unique case (1'b1)
      r && fn == FN_ADDU: begin itype[T_ADDU] = 1'b1; cls = C_ALU_R; end
      r && fn == FN_SUBU: begin itype[T_SUBU] = 1'b1; cls = C_ALU_R; end
      r && fn == FN_SLL:  begin itype[T_SLL] = 1'b1; cls = C_ALU_R; end
      r && fn == FN_JR:   begin itype[T_JR] = 1'b1; cls = C_JR; end
      op == OP_ORI:       begin itype[T_ORI] = 1'b1; cls = C_ALU_I; end
      op == OP_LW:        begin itype[T_LW] = 1'b1; cls = C_LOAD; end
      op == OP_SW:        begin itype[T_SW] = 1'b1; cls = C_STORE; end
      op == OP_BEQ:       begin itype[T_BEQ] = 1'b1; cls = C_BR; end
      op == OP_LUI:       begin itype[T_LUI] = 1'b1; cls = C_ALU_I; end
      op == OP_J:         begin itype[T_J] = 1'b1; cls = C_J; end
      op == OP_JAL:       begin itype[T_JAL] = 1'b1; cls = C_JAL; end
      EXT && op == OP_ADDIU: begin itype[T_ADDIU] = 1'b1; cls = C_ALU_I; end
      EXT && op == OP_ANDI:  begin itype[T_ANDI] = 1'b1; cls = C_ALU_I; end
      EXT && op == OP_BNE:   begin itype[T_BNE] = 1'b1; cls = C_BR; end
      EXT && op == OP_LB:    begin itype[T_LB] = 1'b1; cls = C_LOAD; end
      EXT && op == OP_SB:    begin itype[T_SB] = 1'b1; cls = C_STORE; end
      EXT && r && fn == FN_SLT:  begin itype[T_SLT] = 1'b1; cls = C_ALU_R; end
      EXT && r && fn == FN_JALR: begin itype[T_JALR] = 1'b1; cls = C_JALR; end
      default: itype[NUM_TYPES-1] = 1'b1;
    endcase
  end

  assign hz      = class_info(cls);
  assign tuse_rs = hz.tuse_rs;
  assign tuse_rt = hz.tuse_rt;
  assign tnew    = hz.tnew;
  assign illegal = (cls == C_ERR);

  always_comb begin
    dst = 5'd0;
    unique case (hz.dsel)
      D_RD:    dst = instr[15:11];
      D_RT:    dst = instr[20:16];
      D_R31:   dst = 5'd31;
      default: dst = 5'd0;
    endcase
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// D-stage pipe register: one-cycle decode with valid/ready, stall, flush,
// Tnew countdown while held, saturating illegal-instruction counter.
module instr_decode_pipe
  import instr_decode_pipe_pkg::*;
#(
  parameter int NUM_TYPES = 64,
  parameter int EXT_EN    = 1,
  parameter int ERRCNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr_in,
  input  logic [31:0]          pc_in,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_TYPES-1:0] instr_type,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [4:0]           shamt,
  output logic [15:0]          imm16,
  output logic [31:0]          pc_out,
  output logic [4:0]           dst,
  output logic [1:0]           tuse_rs,
  output logic [1:0]           tuse_rt,
  output logic [1:0]           tnew,
  output logic [ERRCNT_W-1:0]  err_count
);

  logic [NUM_TYPES-1:0] d_type;
  logic [4:0]           d_dst;
  logic [1:0]           d_trs;
  logic [1:0]           d_trt;
  logic [1:0]           d_tnew;
  logic                 d_ill;
  logic                 accept;

  instr_type_lut #(
    .NUM_TYPES(NUM_TYPES),
    .EXT_EN   (EXT_EN)
  ) u_lut (
    .instr  (instr_in),
    .itype  (d_type),
    .dst    (d_dst),
    .tuse_rs(d_trs),
    .tuse_rt(d_trt),
    .tnew   (d_tnew),
    .illegal(d_ill)
  );

  assign in_ready = (!out_valid || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      instr_type <= '0;
      rs         <= '0;
      rt         <= '0;
      rd         <= '0;
      shamt      <= '0;
      imm16      <= '0;
      pc_out     <= '0;
      dst        <= '0;
      tuse_rs    <= TUSE_NONE;
      tuse_rt    <= TUSE_NONE;
      tnew       <= TNEW_NONE;
      err_count  <= '0;
    end else if (flush) begin
      // flush beats a coincident accept: the input word is dropped
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      instr_type <= d_type;
      rs         <= instr_in[25:21];
      rt         <= instr_in[20:16];
      rd         <= instr_in[15:11];
      shamt      <= instr_in[10:6];
      imm16      <= instr_in[15:0];
      pc_out     <= pc_in;
      dst        <= d_dst;
      tuse_rs    <= d_trs;
      tuse_rt    <= d_trt;
      tnew       <= d_tnew;
      if (d_ill && err_count != '1)
        err_count <= err_count + ERRCNT_W'(1);
    end else if (out_valid && stall) begin
      // held entry ages: result gets one cycle closer
      if (tnew != 2'd0)
        tnew <= tnew - 2'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed testbench for instr_decode_pipe: three instances (default,
// EXT_EN=0, ERRCNT_W=2) share one stimulus stream.
module tb_instr_decode_pipe;
  import instr_decode_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        out_ready;

  logic        ov_a, ir_a, ov_b, ir_b, ov_c, ir_c;
  logic [63:0] ty_a, ty_b, ty_c;
  logic [4:0]  rs_a, rt_a, rd_a, sh_a, dst_a;
  logic [4:0]  rs_b, rt_b, rd_b, sh_b, dst_b;
  logic [4:0]  rs_c, rt_c, rd_c, sh_c, dst_c;
  logic [15:0] imm_a, imm_b, imm_c;
  logic [31:0] pc_a, pc_b, pc_c;
  logic [1:0]  trs_a, trt_a, tn_a;
  logic [1:0]  trs_b, trt_b, tn_b;
  logic [1:0]  trs_c, trt_c, tn_c;
  logic [15:0] ec_a, ec_b;
  logic [1:0]  ec_c;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] ONE    = 64'd1;
  localparam logic [63:0] B_ERR  = ONE << 63;
  localparam logic [63:0] B_ADDU = ONE << T_ADDU;
  localparam logic [63:0] B_LW   = ONE << T_LW;
  localparam logic [63:0] B_SW   = ONE << T_SW;
  localparam logic [63:0] B_BEQ  = ONE << T_BEQ;
  localparam logic [63:0] B_SLL  = ONE << T_SLL;
  localparam logic [63:0] B_JR   = ONE << T_JR;
  localparam logic [63:0] B_JAL  = ONE << T_JAL;
  localparam logic [63:0] B_ADDI = ONE << T_ADDIU;

  always #5 clk = ~clk;

  instr_decode_pipe u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_a),
    .instr_in(instr_in), .pc_in(pc_in), .stall(stall), .flush(flush),
    .out_valid(ov_a), .out_ready(out_ready), .instr_type(ty_a),
    .rs(rs_a), .rt(rt_a), .rd(rd_a), .shamt(sh_a), .imm16(imm_a),
    .pc_out(pc_a), .dst(dst_a), .tuse_rs(trs_a), .tuse_rt(trt_a),
    .tnew(tn_a), .err_count(ec_a)
  );

  instr_decode_pipe #(.EXT_EN(0)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_b),
    .instr_in(instr_in), .pc_in(pc_in), .stall(stall), .flush(flush),
    .out_valid(ov_b), .out_ready(out_ready), .instr_type(ty_b),
    .rs(rs_b), .rt(rt_b), .rd(rd_b), .shamt(sh_b), .imm16(imm_b),
    .pc_out(pc_b), .dst(dst_b), .tuse_rs(trs_b), .tuse_rt(trt_b),
    .tnew(tn_b), .err_count(ec_b)
  );

  instr_decode_pipe #(.ERRCNT_W(2)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_c),
    .instr_in(instr_in), .pc_in(pc_in), .stall(stall), .flush(flush),
    .out_valid(ov_c), .out_ready(out_ready), .instr_type(ty_c),
    .rs(rs_c), .rt(rt_c), .rd(rd_c), .shamt(sh_c), .imm16(imm_c),
    .pc_out(pc_c), .dst(dst_c), .tuse_rs(trs_c), .tuse_rt(trt_c),
    .tnew(tn_c), .err_count(ec_c)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    instr_in = '0;
    pc_in = '0;
    #3;
    n_cmp++; if (ov_a !== 1'b0) begin n_bad++; $display("FAIL rst_ov got %0b want 0", ov_a); end
    n_cmp++; if (ty_a !== 64'd0) begin n_bad++; $display("FAIL rst_type got %h want 0", ty_a); end
    n_cmp++; if (trs_a !== 2'd3) begin n_bad++; $display("FAIL rst_trs got %0d want 3", trs_a); end
    n_cmp++; if (trt_a !== 2'd3) begin n_bad++; $display("FAIL rst_trt got %0d want 3", trt_a); end
    n_cmp++; if (ec_a !== 16'd0) begin n_bad++; $display("FAIL rst_ec got %0d want 0", ec_a); end
    n_cmp++; if (pc_a !== 32'd0) begin n_bad++; $display("FAIL rst_pc got %h want 0", pc_a); end
    n_cmp++; if (tn_a !== 2'd0) begin n_bad++; $display("FAIL rst_tnew got %0d want 0", tn_a); end
    step();
    reset = 1'b0;
    n_cmp++; if (ir_a !== 1'b1) begin n_bad++; $display("FAIL rst_inrdy got %0b want 1", ir_a); end
  endtask

  task automatic test_addu;
    in_valid = 1'b1;
    instr_in = 32'h0085_1821;
    pc_in = 32'h100;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (ov_a !== 1'b1) begin n_bad++; $display("FAIL addu_ov got %0b want 1", ov_a); end
    n_cmp++; if (ty_a !== B_ADDU) begin n_bad++; $display("FAIL addu_type got %h want %h", ty_a, B_ADDU); end
    n_cmp++; if (dst_a !== 5'd3) begin n_bad++; $display("FAIL addu_dst got %0d want 3", dst_a); end
    n_cmp++; if (tn_a !== 2'd1) begin n_bad++; $display("FAIL addu_tnew got %0d want 1", tn_a); end
    n_cmp++; if (trs_a !== 2'd1) begin n_bad++; $display("FAIL addu_trs got %0d want 1", trs_a); end
    n_cmp++; if (trt_a !== 2'd1) begin n_bad++; $display("FAIL addu_trt got %0d want 1", trt_a); end
    n_cmp++; if ({rs_a, rt_a, rd_a} !== {5'd4, 5'd5, 5'd3}) begin n_bad++; $display("FAIL addu_regs got %0d %0d %0d want 4 5 3", rs_a, rt_a, rd_a); end
    n_cmp++; if (pc_a !== 32'h100) begin n_bad++; $display("FAIL addu_pc got %h want 100", pc_a); end
    step();
    n_cmp++; if (ov_a !== 1'b0) begin n_bad++; $display("FAIL drain_ov got %0b want 0", ov_a); end
  endtask

  task automatic test_stall;
    logic [1:0] exp_tn;
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr_in = 32'h8C82_0004;
    pc_in = 32'h200;
    step();
    n_cmp++; if (tn_a !== 2'd2) begin n_bad++; $display("FAIL lw_tnew0 got %0d want 2", tn_a); end
    n_cmp++; if (ty_a !== B_LW) begin n_bad++; $display("FAIL lw_type got %h want %h", ty_a, B_LW); end
    n_cmp++; if (dst_a !== 5'd2) begin n_bad++; $display("FAIL lw_dst got %0d want 2", dst_a); end
    n_cmp++; if ({trs_a, trt_a} !== {2'd1, 2'd3}) begin n_bad++; $display("FAIL lw_tuse got %0d %0d want 1 3", trs_a, trt_a); end
    stall = 1'b1;
    instr_in = 32'h0085_1821;
    pc_in = 32'h204;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_tn = (i == 0) ? 2'd1 : 2'd0;
      n_cmp++; if (tn_a !== exp_tn) begin n_bad++; $display("FAIL stall_tnew%0d got %0d want %0d", i, tn_a, exp_tn); end
      n_cmp++; if (ir_a !== 1'b0) begin n_bad++; $display("FAIL stall_inrdy%0d got %0b want 0", i, ir_a); end
      n_cmp++; if (ov_a !== 1'b1) begin n_bad++; $display("FAIL stall_ov%0d got %0b want 1", i, ov_a); end
      n_cmp++; if (ty_a !== B_LW) begin n_bad++; $display("FAIL stall_type%0d got %h want %h", i, ty_a, B_LW); end
      n_cmp++; if ({imm_a, dst_a, pc_a} !== {16'h4, 5'd2, 32'h200}) begin n_bad++; $display("FAIL stall_fields%0d got %h %0d %h want 4 2 200", i, imm_a, dst_a, pc_a); end
    end
    stall = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++; if (ov_a !== 1'b0) begin n_bad++; $display("FAIL unstall_ov got %0b want 0", ov_a); end
  endtask

  task automatic test_ext;
    do_reset();
    in_valid = 1'b1;
    instr_in = 32'h2442_0001;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (ty_a !== B_ADDI) begin n_bad++; $display("FAIL ext1_type got %h want %h", ty_a, B_ADDI); end
    n_cmp++; if (dst_a !== 5'd2) begin n_bad++; $display("FAIL ext1_dst got %0d want 2", dst_a); end
    n_cmp++; if (ec_a !== 16'd0) begin n_bad++; $display("FAIL ext1_ec got %0d want 0", ec_a); end
    n_cmp++; if (ty_b !== B_ERR) begin n_bad++; $display("FAIL ext0_type got %h want %h", ty_b, B_ERR); end
    n_cmp++; if (ec_b !== 16'd1) begin n_bad++; $display("FAIL ext0_ec got %0d want 1", ec_b); end
    n_cmp++; if ({dst_b, tn_b, trs_b} !== {5'd0, 2'd0, 2'd3}) begin n_bad++; $display("FAIL ext0_hz got %0d %0d %0d want 0 0 3", dst_b, tn_b, trs_b); end
  endtask

  task automatic test_flush;
    do_reset();
    flush = 1'b1;
    in_valid = 1'b1;
    instr_in = 32'h0C00_0010;
    step();
    n_cmp++; if (ov_a !== 1'b0) begin n_bad++; $display("FAIL flush_ov got %0b want 0", ov_a); end
    instr_in = 32'hFC00_0000;
    step();
    n_cmp++; if (ec_a !== 16'd0) begin n_bad++; $display("FAIL flush_ec got %0d want 0", ec_a); end
    n_cmp++; if (ec_c !== 2'd0) begin n_bad++; $display("FAIL flush_ecw2 got %0d want 0", ec_c); end
    flush = 1'b0;
    instr_in = 32'h0C00_0010;
    step();
    in_valid = 1'b0;
    n_cmp++; if (ov_a !== 1'b1) begin n_bad++; $display("FAIL jal_ov got %0b want 1", ov_a); end
    n_cmp++; if (ty_a !== B_JAL) begin n_bad++; $display("FAIL jal_type got %h want %h", ty_a, B_JAL); end
    n_cmp++; if (dst_a !== 5'd31) begin n_bad++; $display("FAIL jal_dst got %0d want 31", dst_a); end
    n_cmp++; if ({tn_a, trs_a, trt_a} !== {2'd0, 2'd3, 2'd3}) begin n_bad++; $display("FAIL jal_hz got %0d %0d %0d want 0 3 3", tn_a, trs_a, trt_a); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [4];
    logic [63:0] et [4];
    logic [10:0] eh [4];
    w[0] = 32'hAC82_0004; et[0] = B_SW;  eh[0] = {5'd0, 2'd1, 2'd2, 2'd0};
    w[1] = 32'h1085_0003; et[1] = B_BEQ; eh[1] = {5'd0, 2'd0, 2'd0, 2'd0};
    w[2] = 32'h0000_0000; et[2] = B_SLL; eh[2] = {5'd0, 2'd1, 2'd1, 2'd1};
    w[3] = 32'h03E0_0008; et[3] = B_JR;  eh[3] = {5'd0, 2'd0, 2'd3, 2'd0};
    do_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_in = w[i];
      pc_in = 32'h300 + 32'(4 * i);
      step();
      n_cmp++; if (ty_a !== et[i]) begin n_bad++; $display("FAIL b2b_type%0d got %h want %h", i, ty_a, et[i]); end
      n_cmp++; if ({dst_a, trs_a, trt_a, tn_a} !== eh[i]) begin n_bad++; $display("FAIL b2b_hz%0d got %h want %h", i, {dst_a, trs_a, trt_a, tn_a}, eh[i]); end
      n_cmp++; if (ov_a !== 1'b1) begin n_bad++; $display("FAIL b2b_ov%0d got %0b want 1", i, ov_a); end
    end
    in_valid = 1'b0;
    n_cmp++; if (ec_a !== 16'd0) begin n_bad++; $display("FAIL sll0_ec got %0d want 0", ec_a); end
    step();
  endtask

  task automatic test_errsat;
    logic [1:0] exp_c;
    do_reset();
    instr_in = 32'hFC00_0000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_c = (i < 3) ? 2'(i + 1) : 2'd3;
      n_cmp++; if (ec_c !== exp_c) begin n_bad++; $display("FAIL sat_ec%0d got %0d want %0d", i, ec_c, exp_c); end
      n_cmp++; if (ec_a !== 16'(i + 1)) begin n_bad++; $display("FAIL cnt_ec%0d got %0d want %0d", i, ec_a, i + 1); end
      n_cmp++; if (ty_a !== B_ERR) begin n_bad++; $display("FAIL ill_type%0d got %h want %h", i, ty_a, B_ERR); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr_in = 32'h0085_1821;
    step();
    in_valid = 1'b0;
    stall = 1'b1;
    step();
    n_cmp++; if (ov_a !== 1'b1) begin n_bad++; $display("FAIL pre_ar_ov got %0b want 1", ov_a); end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (ov_a !== 1'b0) begin n_bad++; $display("FAIL ar_ov got %0b want 0", ov_a); end
    n_cmp++; if ({trs_a, trt_a} !== 4'hF) begin n_bad++; $display("FAIL ar_tuse got %0d %0d want 3 3", trs_a, trt_a); end
    n_cmp++; if ({ty_a, dst_a, ec_a} !== '0) begin n_bad++; $display("FAIL ar_clear got %h %0d %0d want 0", ty_a, dst_a, ec_a); end
    #1;
    reset = 1'b0;
    stall = 1'b0;
    step();
    n_cmp++; if (ov_a !== 1'b0) begin n_bad++; $display("FAIL post_ar_ov got %0b want 0", ov_a); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_stall();
    test_ext();
    test_flush();
    test_back_to_back();
    test_errsat();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_pipe.md
INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

Interface
REQ-001 SHALL have parameter NUM_TYPES, default 64, one-hot instruction-type vector width, minimum 20.
REQ-002 SHALL have parameter EXT_EN, default 1; 1 enables the extended instruction subset.
REQ-003 SHALL have parameter ERRCNT_W, default 16, width of the illegal-instruction counter.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port in_valid  input  1  F-stage instruction present.
REQ-008 SHALL have port in_ready  output  1  stage accepts instruction this cycle.
REQ-009 SHALL have port instr_in  input  32  raw instruction word.
REQ-010 SHALL have port pc_in  input  32  PC of instr_in.
REQ-011 SHALL have port stall  input  1  hazard-unit hold request.
REQ-012 SHALL have port flush  input  1  kill the held entry.
REQ-013 SHALL have port out_valid  output  1  decoded entry valid.
REQ-014 SHALL have port out_ready  input  1  E stage consumes entry.
REQ-015 SHALL have port instr_type  output  NUM_TYPES  one-hot decoded type.
REQ-016 SHALL have ports rs, rt, rd, shamt  output  5 each; imm16  output  16; pc_out  output  32: registered fields.
REQ-017 SHALL have port dst  output  5  destination GPR, 0 if none.
REQ-018 SHALL have ports tuse_rs, tuse_rt  output  2 each  operand use time; 3 means unused.
REQ-019 SHALL have port tnew  output  2  cycles until result is available.
REQ-020 SHALL have port err_count  output  ERRCNT_W  saturating illegal-instruction count.

Function
REQ-021 Base set SHALL be: addu, subu, sll, jr (R-type, opcode 0), ori, lw, sw, beq, lui, j, jal; the extended set when EXT_EN=1 SHALL be: addiu, andi, bne, lb, sb, slt, jalr.
REQ-022 Each recognised type SHALL set exactly one fixed bit in instr_type; bit NUM_TYPES-1 is the error bit.
REQ-023 An unrecognised word, or an extended instruction with EXT_EN=0, SHALL set only the error bit.
REQ-024 Latency SHALL be one cycle: an accepted word appears on the outputs at the next rising edge.
REQ-025 in_ready SHALL be (!out_valid || out_ready) && !stall.
REQ-026 Accept occurs when in_valid && in_ready; the output register loads and out_valid=1.
REQ-027 When out_valid && out_ready && no accept occurs, out_valid SHALL become 0.
REQ-028 flush SHALL clear out_valid at the next edge; when flush and accept coincide, flush wins and the input is dropped.
REQ-029 While stalled with out_valid=1, all fields SHALL hold, except tnew, which SHALL decrement by 1 per cycle and saturate at 0.
REQ-030 dst SHALL be: rd for addu/subu/sll/slt/jalr; rt for ori/lw/lb/lui/addiu/andi; 31 for jal; otherwise 0.
REQ-031 tnew SHALL be 1 for ALU types, 2 for loads, and 0 otherwise.
REQ-032 tuse_rs SHALL be 0 for beq/bne/jr/jalr, 1 for ALU/load/store types, and 3 otherwise.
REQ-033 tuse_rt SHALL be 0 for beq/bne, 1 for addu/subu/sll/slt, 2 for sw/sb, and 3 otherwise.
REQ-034 err_count SHALL increment on each accepted illegal word that is not simultaneously flushed, and saturate at all-ones.
REQ-035 sll with the all-zero word SHALL decode as sll with dst=0, and SHALL NOT count as an error.

Reset
REQ-036 reset SHALL asynchronously clear out_valid, instr_type, all fields, pc_out, dst, tnew and err_count to 0.
REQ-037 reset SHALL set tuse_rs and tuse_rt to 3.
REQ-038 Reset asserted mid-stall SHALL discard the held entry; no output SHALL persist after reset.

Structure
REQ-039 Opcode/funct constants, type bit indices, and Tuse/Tnew encodings SHALL live in a shared package shared with the hazard unit.
REQ-040 Combinational decoding SHALL be one sub-module, instr_type_lut (instr, EXT_EN -> type, dst, tuse, tnew); the pipe register and counter SHALL live in the top module.

Verification
REQ-041 instr_in=0x00851821 (addu $3,$4,$5), in_valid=1, out_ready=1 -> next cycle: addu bit set, dst=3, tnew=1, tuse_rs=1, tuse_rt=1.
REQ-042 lw 0x8C820004 accepted, then stall=1 for 3 cycles -> tnew 2,1,0,0, in_ready=0, and fields unchanged.
REQ-043 EXT_EN=0 with addiu 0x24420001 -> only bit NUM_TYPES-1 set and err_count=1; with EXT_EN=1 -> addiu bit set, dst=2, err_count=0.
REQ-044 flush=1 in the same cycle as accepting jal 0x0C000010 -> out_valid=0 next cycle and no count change; a following jal yields dst=31 and tnew=0.
REQ-045 ERRCNT_W=2 with 5 illegal words (0xFC000000) -> err_count sequence 1,2,3,3,3.
REQ-046 reset pulsed asynchronously mid-cycle while out_valid=1 -> out_valid=0 immediately and tuse_rs=tuse_rt=3.
